rv_multicycle_ctrl: RTL
=======================

Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences a shared-memory datapath (one memory port for instructions and data, one ALU, IR/ALUOut/MDR holding registers) through the fetch, decode, execute, memory and writeback steps.
- It handshakes with the memory port and counts retired instructions.
- On an unsupported opcode it halts.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- run  in  1  level; enables execution.
- instr  in  32  IR contents; opcode is [6:0], funct3 is [14:12].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe; valid only while mem_req=1.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut.
- alu_src_a  out  2  ALU A select: 00=PC, 01=rs1, 10=old PC.
- alu_src_b  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm.
- alu_op  out  2  00=add, 01=sub/compare, 10=decode funct.
- state_o  out  4  current state encoding.
- halted  out  1  sticky illegal-instruction halt.
- retire_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, HALT=11.
- Reset (rst_n=0, any cycle, including mid-instruction or mid memory request): state=IDLE immediately, all outputs 0, retire_cnt=0, halted=0.
- Default for every output in every state is 0 unless listed below.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_req=1, iord=0.
  - alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write, pc_write (pc_src=0) assert only in a cycle with mem_ready=1; then go to DECODE.
  - With mem_ready=0, hold FETCH with mem_req held high. No request timeout.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011: MEM_ADDR.
  - 0110011: EXEC_R.
  - 0010011: EXEC_I.
  - 1100011 with funct3 000 or 001: BRANCH.
  - anything else: HALT.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Go to MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, iord=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Instruction retires.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready; the instruction retires on the mem_ready cycle.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10. Go to ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10. Go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Instruction retires.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, alu_op=01.
  - taken = (funct3=000 & zero) | (funct3=001 & ~zero).
  - pc_write=taken, pc_src=1.
  - Instruction retires.
- Retire rule:
  - retire_cnt increments by 1, wrapping at 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
- run=0 mid-instruction does not abort; the current instruction completes.
- HALT: halted=1. Stays in HALT until reset; run is ignored. No retire.
- mem_req stays constant while waiting. mem_we/iord do not change while mem_req=1 and mem_ready=0.
- Cycle counts per instruction, with zero-wait memory (mem_ready=1 whenever mem_req=1):
  - load: 5.
  - store: 4.
  - R/I: 4.
  - branch: 3.
- Each memory wait cycle adds 1.

Test Plan:
- Reset then run=1, instr=0x00208033 (add), mem_ready=1 → states 1,2,7,9,1; reg_write=1 only in ALU_WB; retire_cnt=1 after 4 cycles.
- Load 0x0000A103, mem_ready low 3 cycles in MEM_RD → mem_req, iord held high 4 cycles; reg_write and mem_to_reg pulse once; total 8 cycles.
- Store 0x0020A023, zero-wait → mem_we=1 exactly 1 cycle; reg_write never asserted; retire_cnt +1.
- BEQ 0x00208463 with zero=1 → pc_write=1, pc_src=1 in BRANCH. With zero=0 → pc_write=0. BNE (funct3=001) gives the inverse.
- instr=0x0000007F → HALT, halted=1, mem_req=0 for 20 cycles with run=1; rst_n pulse low → IDLE, halted=0, retire_cnt=0.
- rst_n low during FETCH wait (mem_req=1) → mem_req drops the same cycle without a clock edge. Separately, run=0 during EXEC_R → ALU_WB completes, then IDLE.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv_multicycle_ctrl
//   Control FSM for a multi-cycle RV32I datapath. One memory port is shared by
//   instruction fetch and data access. Each instruction walks through fetch,
//   decode, execute, memory and writeback steps. The FSM handshakes with the
//   memory port, counts retired instructions and halts for good on an
//   unsupported opcode.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   run          : level enable; sampled in IDLE and when an instruction retires
//   instr        : IR contents (opcode [6:0], funct3 [14:12])
//   zero         : ALU zero flag, used by BEQ/BNE
//   mem_ready    : memory completes the pending request this cycle
//   mem_req/mem_we/iord          : memory request, write strobe, address select
//   ir_write/pc_write/pc_src     : IR load, PC load and PC source select
//   reg_write/mem_to_reg         : register file write and writeback source
//   alu_src_a/alu_src_b/alu_op   : ALU operand selects and operation class
//   state_o      : current state encoding
//   halted       : high while parked in HALT after an illegal instruction
//   retire_cnt   : retired-instruction counter, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module rv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Operand fields are consumed by the datapath, not by the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    halted     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        // PC+4 is computed by the ALU every fetch cycle; IR and PC only load
        // on the cycle the memory actually returns the instruction.
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Old PC + imm lands in ALUOut as the speculative branch target.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM_ADDR;
        else if (opcode == OP_R)                     state_d = S_EXEC_R;
        else if (opcode == OP_I)                     state_d = S_EXEC_I;
        else if (opcode == OP_BRANCH && (funct3 == 3'b000 || funct3 == 3'b001))
                                                     state_d = S_BRANCH;
        else                                         state_d = S_HALT;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        retire    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retirement is the only point where run=0 takes effect mid-stream.
    retire_cnt_d = retire_cnt_q;
    if (retire) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
      state_d      = run ? S_FETCH : S_IDLE;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign state_o    = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule
